// File: rtl/counter_service.sv
// Request-driven counter bank: FIFO-buffered INC/READ/CLEAR requests, 2-stage pipeline with S2->S1 forwarding.
// Optional CTR_SATURATE_EN makes INC saturate at all-ones instead of wrapping.
module counter_service #(
  parameter int NUM_CTRS   = 64,
  parameter int CTR_W      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_tx,
  input  logic [7:0]       req_srcid,
  input  logic [7:0]       req_dstid,
  input  logic [31:0]      req_arg0,
  input  logic [31:0]      req_arg1,
  input  logic [31:0]      req_arg2,
  output logic             req_full,
  output logic             rsp_tx,
  output logic [7:0]       rsp_dstid,
  output logic [CTR_W-1:0] rsp_value,
  input  logic             rsp_ready,
  output logic             idle,
  output logic [15:0]      err_cnt
);

  localparam int IDX_W = $clog2(NUM_CTRS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    OP_INC   = 2'd0,
    OP_READ  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_BAD   = 2'd3
  } op_e;

  // Requests are decoded on entry so the FIFO holds only what the pipeline needs.
  typedef struct packed {
    logic [7:0]       srcid;
    logic [7:0]       dstid;
    logic [IDX_W-1:0] idx;
    logic [CTR_W-1:0] amt;
    op_e              op;
    logic             bad;
  } req_t;

  req_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [CTR_W-1:0] ctr [NUM_CTRS];

  req_t             push_req;
  req_t             head_req;
  req_t             s1_req;
  logic             s1_valid;
  logic [CTR_W-1:0] s1_val;

  logic             stall;
  logic             pop;
  logic             push;
  logic             drop;
  logic             s2_act;
  logic             s2_good;
  logic             wr_en;
  logic             rsp_load;
  logic             bad_inc;
  logic             fwd;
  logic [CTR_W:0]   inc_sum;
  logic [CTR_W-1:0] inc_res;
  logic [CTR_W-1:0] s2_result;
  logic [CTR_W-1:0] read_val;
  logic             s1_valid_nxt;
  logic             rsp_tx_nxt;
  logic             idle_nxt;
  logic             full_nxt;
  logic [1:0]       err_inc;
  logic [16:0]      err_sum;
  logic [15:0]      err_nxt;
  logic             unused_bits;

  assign head_req    = fifo_mem[rd_ptr];
  assign unused_bits = ^{s1_req.dstid, inc_sum[CTR_W]};

  always_comb begin
    push_req       = '0;
    push_req.srcid = req_srcid;
    push_req.dstid = req_dstid;
    push_req.idx   = req_arg0[IDX_W-1:0];
    push_req.amt   = req_arg1[CTR_W-1:0];
    case (req_arg2)
      32'd0:   push_req.op = OP_INC;
      32'd1:   push_req.op = OP_READ;
      32'd2:   push_req.op = OP_CLEAR;
      default: push_req.op = OP_BAD;
    endcase
    push_req.bad = (push_req.op == OP_BAD) || (req_arg0 >= 32'(NUM_CTRS));
  end

  // A held response freezes both stages; the FIFO keeps accepting.
  always_comb begin
    stall     = rsp_tx & ~rsp_ready;
    pop       = ~stall & (count != '0);
    push      = req_tx & ((count != CNT_W'(FIFO_DEPTH)) | pop);
    drop      = req_tx & ~push;
    count_nxt = count + CNT_W'(push) - CNT_W'(pop);

    s2_act   = s1_valid & ~stall;
    s2_good  = s2_act & ~s1_req.bad;
    bad_inc  = s2_act & s1_req.bad;
    wr_en    = s2_good & ((s1_req.op == OP_INC) | (s1_req.op == OP_CLEAR));
    rsp_load = s2_good & ((s1_req.op == OP_READ) | (s1_req.op == OP_CLEAR));

    inc_sum = {1'b0, s1_val} + {1'b0, s1_req.amt};
`ifdef CTR_SATURATE_EN
    inc_res = inc_sum[CTR_W] ? '1 : inc_sum[CTR_W-1:0];
`else
    inc_res = inc_sum[CTR_W-1:0];
`endif
    case (s1_req.op)
      OP_INC:   s2_result = inc_res;
      OP_CLEAR: s2_result = '0;
      default:  s2_result = s1_val;
    endcase

    fwd      = wr_en & (s1_req.idx == head_req.idx);
    read_val = fwd ? s2_result : ctr[head_req.idx];

    s1_valid_nxt = stall ? s1_valid : pop;
    rsp_tx_nxt   = stall | rsp_load;
    idle_nxt     = (count_nxt == '0) & ~s1_valid_nxt & ~rsp_tx_nxt;
    full_nxt     = (count_nxt >= CNT_W'(FIFO_DEPTH - 2));

    err_inc = 2'(drop) + 2'(bad_inc);
    err_sum = {1'b0, err_cnt} + 17'(err_inc);
    err_nxt = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_req;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      s1_req <= head_req;
      s1_val <= read_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CTRS; i++) begin
        ctr[i] <= '0;
      end
    end else if (wr_en) begin
      ctr[s1_req.idx] <= s2_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      s1_valid  <= 1'b0;
      rsp_tx    <= 1'b0;
      rsp_dstid <= '0;
      rsp_value <= '0;
      req_full  <= 1'b0;
      idle      <= 1'b0;
      err_cnt   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count    <= count_nxt;
      s1_valid <= s1_valid_nxt;
      rsp_tx   <= rsp_tx_nxt;
      if (rsp_load) begin
        rsp_dstid <= s1_req.srcid;
        rsp_value <= s1_val;
      end
      req_full <= full_nxt;
      idle     <= idle_nxt;
      err_cnt  <= err_nxt;
    end
  end

endmodule

// File: tb/tb_counter_service.sv
// Randomized self-checking bench for counter_service against an in-order transaction model.
module tb_counter_service;

  localparam int NUM_CTRS = 64;

  typedef struct {
    logic [7:0]  dst;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_tx = 1'b0;
  logic [7:0]  req_srcid = '0;
  logic [7:0]  req_dstid = '0;
  logic [31:0] req_arg0 = '0;
  logic [31:0] req_arg1 = '0;
  logic [31:0] req_arg2 = '0;
  logic        req_full;
  logic        rsp_tx;
  logic [7:0]  rsp_dstid;
  logic [31:0] rsp_value;
  logic        rsp_ready = 1'b1;
  logic        idle;
  logic [15:0] err_cnt;

  int          nVectors = 0;
  int          nMiscompares = 0;
  int          readyMode = 0;
  int          errExp = 0;
  logic [31:0] modelCtr [NUM_CTRS];
  exp_t        expQ [$];
  logic [31:0] lastRspValue;

  counter_service dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_tx    (req_tx),
    .req_srcid (req_srcid),
    .req_dstid (req_dstid),
    .req_arg0  (req_arg0),
    .req_arg1  (req_arg1),
    .req_arg2  (req_arg2),
    .req_full  (req_full),
    .rsp_tx    (rsp_tx),
    .rsp_dstid (rsp_dstid),
    .rsp_value (rsp_value),
    .rsp_ready (rsp_ready),
    .idle      (idle),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NUM_CTRS; i++) modelCtr[i] = '0;
    errExp = 0;
    expQ.delete();
  endtask

  // In-order reference: each accepted request acts on the counters exactly once, in arrival order.
  task automatic modelPush(input logic [7:0] src, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2);
    logic [32:0] sum;
    exp_t        e;
    if (a0 >= NUM_CTRS || a2 > 2) begin
      errExp++;
    end else if (a2 == 0) begin
      sum = {1'b0, modelCtr[a0[5:0]]} + {1'b0, a1};
`ifdef CTR_SATURATE_EN
      modelCtr[a0[5:0]] = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
`else
      modelCtr[a0[5:0]] = sum[31:0];
`endif
    end else begin
      e.dst = src;
      e.val = modelCtr[a0[5:0]];
      expQ.push_back(e);
      if (a2 == 2) modelCtr[a0[5:0]] = '0;
    end
  endtask

  task automatic applyStimulus(input bit tx, input logic [7:0] src, input logic [7:0] dst,
                               input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
    req_tx    = tx;
    req_srcid = src;
    req_dstid = dst;
    req_arg0  = a0;
    req_arg1  = a1;
    req_arg2  = a2;
    case (readyMode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'b0;
      default: rsp_ready = ($urandom_range(0, 3) != 0);
    endcase
    @(posedge clk);
    #1;
    req_tx = 1'b0;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 8'h00, 8'h00, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic sendReq(input logic [7:0] src, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2);
    int guard = 0;
    while (req_full === 1'b1 && guard < 200) begin
      idleCycle();
      guard++;
    end
    if (guard >= 200) begin
      checkOutput("full_timeout", 64'(req_full), 64'd0);
    end else begin
      applyStimulus(1'b1, src, 8'($urandom), a0, a1, a2);
      modelPush(src, a0, a1, a2);
    end
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    readyMode = 0;
    while (idle !== 1'b1 && n < budget) begin
      idleCycle();
      n++;
    end
    checkOutput("idle_reached", 64'(idle), 64'd1);
  endtask

  task automatic waitRsp(input int budget);
    int n = 0;
    while (rsp_tx !== 1'b1 && n < budget) begin
      idleCycle();
      n++;
    end
    checkOutput("rsp_seen", 64'(rsp_tx), 64'd1);
  endtask

  task automatic readCounter(input logic [5:0] idx, input logic [31:0] expVal, input string tag);
    lastRspValue = 'x;
    sendReq(8'hA0 ^ {2'b00, idx}, {26'h0, idx}, 32'h0, 32'd1);
    waitIdle(100);
    checkOutput(tag, 64'(lastRspValue), 64'(expVal));
  endtask

  task automatic resetDut();
    req_tx = 1'b0;
    rst_n  = 1'b0;
    modelReset();
    #1;
    checkOutput("reset_rsp_tx", 64'(rsp_tx), 64'd0);
    checkOutput("reset_rsp_value", 64'(rsp_value), 64'd0);
    checkOutput("reset_req_full", 64'(req_full), 64'd0);
    checkOutput("reset_err_cnt", 64'(err_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_after_reset", 64'(idle), 64'd1);
  endtask

  // Every cycle a response is offered it must match the oldest outstanding model response.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_tx === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("rsp_spurious", 64'(rsp_tx), 64'd0);
      end else begin
        checkOutput("rsp_dstid", 64'(rsp_dstid), 64'(expQ[0].dst));
        checkOutput("rsp_value", 64'(rsp_value), 64'(expQ[0].val));
        if (rsp_ready === 1'b1) begin
          lastRspValue = rsp_value;
          void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    int          sent;
    int          r;
    logic [31:0] a0;
    logic [31:0] a2;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    resetDut();

    for (int i = 0; i < 1000; i++) sendReq(8'h11, 32'd5, 32'd1, 32'd0);
    readCounter(6'd5, 32'd1000, "inc_stream_idx5");
    checkOutput("inc_stream_err", 64'(err_cnt), 64'd0);

    for (int i = 0; i < 500; i++) begin
      sendReq(8'h21, 32'd1, 32'd2, 32'd0);
      sendReq(8'h22, 32'd18, 32'd1, 32'd0);
    end
    readCounter(6'd1, 32'd1000, "interleave_idx1");
    readCounter(6'd18, 32'd500, "interleave_idx18");

    sendReq(8'h31, 32'd3, 32'd0, 32'd2);
    sendReq(8'h31, 32'd3, 32'hFFFF_FFFF, 32'd0);
    sendReq(8'h31, 32'd3, 32'd2, 32'd0);
`ifdef CTR_SATURATE_EN
    readCounter(6'd3, 32'hFFFF_FFFF, "overflow_idx3");
`else
    readCounter(6'd3, 32'd1, "overflow_idx3");
`endif

    resetDut();
    sendReq(8'h41, 32'd64, 32'd9, 32'd0);
    sendReq(8'h42, 32'd2, 32'd9, 32'd7);
    waitIdle(50);
    readyMode = 1;
    sendReq(8'h43, 32'd0, 32'd0, 32'd1);
    waitRsp(20);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'h50 + 8'(i), 8'h0, 32'(i), 32'h0, 32'd1);
      modelPush(8'h50 + 8'(i), 32'(i), 32'h0, 32'd1);
    end
    applyStimulus(1'b1, 8'h5F, 8'h0, 32'd2, 32'd5, 32'd0);
    errExp++;
    checkOutput("full_flag", 64'(req_full), 64'd1);
    checkOutput("err_after_drop", 64'(err_cnt), 64'd3);
    waitIdle(100);
    readCounter(6'd0, 32'd0, "drop_idx0_unchanged");
    readCounter(6'd2, 32'd0, "drop_idx2_unchanged");
    checkOutput("drop_err_total", 64'(err_cnt), 64'(errExp));

    sendReq(8'h61, 32'd7, 32'h55, 32'd0);
    readyMode = 1;
    sendReq(8'h62, 32'd7, 32'd0, 32'd1);
    waitRsp(20);
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      if (sent < 10 && req_full !== 1'b1) begin
        applyStimulus(1'b1, 8'h63, 8'h0, 32'd7, 32'd3, 32'd0);
        modelPush(8'h63, 32'd7, 32'd3, 32'd0);
        sent++;
      end else begin
        idleCycle();
      end
    end
    checkOutput("hold_rsp_tx", 64'(rsp_tx), 64'd1);
    checkOutput("hold_rsp_value", 64'(rsp_value), 64'h55);
    checkOutput("hold_full", 64'(req_full), 64'd1);
    readyMode = 0;
    while (sent < 10) begin
      sendReq(8'h63, 32'd7, 32'd3, 32'd0);
      sent++;
    end
    waitIdle(100);
    readCounter(6'd7, 32'h73, "hold_idx7_total");

    readyMode = 2;
    for (int i = 0; i < 300; i++) begin
      r  = int'($urandom_range(0, 19));
      a0 = (r < 18) ? 32'(r % 8) : 32'd64 + 32'($urandom_range(0, 1000));
      r  = int'($urandom_range(0, 19));
      a2 = (r < 12) ? 32'd0 : (r < 16) ? 32'd1 : (r < 18) ? 32'd2 : 32'($urandom_range(3, 255));
      sendReq(8'($urandom), a0, (r % 5 == 0) ? $urandom : 32'($urandom_range(0, 100)), a2);
      if ($urandom_range(0, 3) == 0) idleCycle();
    end
    waitIdle(300);
    for (int i = 0; i < 8; i++) readCounter(6'(i), modelCtr[i], "random_readback");
    checkOutput("random_err_cnt", 64'(err_cnt), 64'(errExp));

    readyMode = 2;
    for (int i = 0; i < 25; i++) sendReq(8'h71, 32'd4, 32'd1, (i % 5 == 4) ? 32'd1 : 32'd0);
    resetDut();
    checkOutput("midreset_rsp_tx", 64'(rsp_tx), 64'd0);
    readCounter(6'd4, 32'd0, "midreset_idx4");
    readCounter(6'd7, 32'd0, "midreset_idx7");

    checkOutput("rsp_outstanding", 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
